// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared widths, FSM state encoding and RAM read/write encoding
// for the RAM-backed byte FIFO controller.
`default_nettype none

package ram_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fifo_state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage : ram_fifo_pkg

`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: ADDR_W-bit wrapping queue pointer with increment enable.
`default_nettype none

module ram_fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // Wraps from all-ones to zero through natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule : ram_fifo_ptr

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: drives a single-port synchronous RAM as a byte FIFO with a
// one-entry show-ahead output register.
`default_nettype none

module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] c_DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

  fifo_state_t       r_state;
  fifo_state_t       w_state_nxt;
  logic [ADDR_W:0]   r_level;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic              w_fetch_now;
  logic              w_fetch_done;
  logic              w_wr_fire;
  logic              w_rd_fire;

  // A fetch starts only when the head register is empty or being drained.
  assign w_fetch_now  = (r_state == ST_IDLE) && (r_level != '0) &&
                        (!r_rd_valid || rd_ready);
  assign w_fetch_done = (r_state == ST_FETCH);

  assign wr_ready  = (r_level < c_DEPTH_LVL) && !w_fetch_now;
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_rd_fire = r_rd_valid && rd_ready;

  ram_fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wr_fire),
    .o_ptr (w_wr_ptr)
  );

  ram_fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_fetch_done),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The port defaults to a harmless read of the head location; a write only
  // takes it over when one fires, which never coincides with a fetch launch.
  always_comb begin
    w_state_nxt = r_state;
    ram_addr    = w_rd_ptr;
    ram_rw      = RW_READ;
    ram_wdata   = wr_data;
    case (r_state)
      ST_IDLE: begin
        if (w_fetch_now) begin
          w_state_nxt = ST_FETCH;
        end else if (w_wr_fire) begin
          ram_addr = w_wr_ptr;
          ram_rw   = RW_WRITE;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_IDLE;
        if (w_wr_fire) begin
          ram_addr = w_wr_ptr;
          ram_rw   = RW_WRITE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_wr_fire, w_fetch_done})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A completing fetch refills the head even when the old head leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_fetch_done) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= ram_rdata;
    end else if (w_rd_fire) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign level    = r_level;

endmodule : ram_fifo_ctrl

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: ram_fifo_ctrl with a 16x8 synchronous RAM model, vector
// table plus scoreboard-checked multi-cycle sequences.
`default_nettype none

module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic [3:0] ram_addr;
  logic       ram_rw;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .level     (level),
    .ram_addr  (ram_addr),
    .ram_rw    (ram_rw),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // 16x8 single-port synchronous RAM: o_data registered on read cycles.
  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_wdata;
    else        ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted bytes pushed on wr_fire, compared on rd_fire.
  always @(posedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) sb_q.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        n_pops++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pop", {24'h0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_order", {24'h0, rd_data}, {24'h0, sb_q.pop_front()});
        end
      end
    end
  end

  always @(negedge rst_n) sb_q.delete();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] start, input int n, input int max_cyc);
    logic [7:0] d;
    int cnt;
    logic acc;
    d = start;
    cnt = 0;
    for (int c = 0; c < max_cyc && cnt < n; c++) begin
      wr_valid = 1'b1;
      wr_data  = d;
      #1;
      acc = wr_ready;
      tick();
      if (acc) begin
        d++;
        cnt++;
      end
    end
    wr_valid = 1'b0;
    chk("push_count", cnt, n);
  endtask

  task automatic drain(input int max_cyc);
    logic done;
    done = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (!rd_valid && level == 5'd0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_done", done, 1'b1);
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       exp_wr_ready;
    logic [4:0] exp_level;
    logic       exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int pulses, consec, pops0;
    logic prev, got;

    vecs[0] = '{1'b1, 8'haa, 1'b0, 1'b1, 5'd1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h55, 1'b0, 1'b1, 5'd1, 1'b1, 8'haa};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b1, 8'haa};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b1, 8'h55};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00};

    #1;
    chk("reset_level", level, 5'd0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_data", rd_data, 8'h00);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();

    // Basic write / fetch / read vectors.
    for (int i = 0; i < 7; i++) begin
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].wd;
      rd_ready = vecs[i].rr;
      #1;
      chk($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].exp_wr_ready);
      tick();
      chk($sformatf("v%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("ram_addr0", mem[0], 8'haa);
    chk("ram_addr1", mem[1], 8'h55);

    // Fill: 17 bytes occupy 16 RAM entries plus the head register.
    push_bytes(8'h00, 17, 100);
    chk("full_level", level, 5'd16);
    chk("full_rd_valid", rd_valid, 1'b1);
    chk("full_head", rd_data, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h11;
      #1;
      chk("full_stall_wr_ready", wr_ready, 1'b0);
      tick();
    end
    wr_valid = 1'b0;
    chk("full_stall_level", level, 5'd16);

    // Drain: one byte every second cycle, in order.
    pulses = 0;
    consec = 0;
    prev = 1'b0;
    got = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (rd_valid) begin
        pulses++;
        if (prev) consec++;
      end
      prev = rd_valid;
      if (!rd_valid && level == 5'd0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_finished", got, 1'b1);
    chk("drain_pulses", pulses, 17);
    chk("drain_back_to_back", consec, 0);
    chk("drain_level", level, 5'd0);
    chk("drain_sb_empty", sb_q.size(), 0);

    // Wrap-around with concurrent writes and reads.
    pops0 = n_pops;
    rd_ready = 1'b1;
    push_bytes(8'h80, 20, 200);
    drain(100);
    chk("wrap_pops", n_pops - pops0, 20);
    chk("wrap_level", level, 5'd0);

    // Write during a FETCH cycle leaves level unchanged.
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h10;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("sim_fetch_blocks_write", wr_ready, 1'b0);
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'h2a;
    #1;
    chk("sim_fetch_wr_ready", wr_ready, 1'b1);
    chk("sim_level_before", level, 5'd1);
    tick();
    wr_valid = 1'b0;
    chk("sim_level_after", level, 5'd1);
    chk("sim_head", rd_data, 8'h10);
    drain(40);
    chk("sim_sb_empty", sb_q.size(), 0);

    // Async reset with data in flight.
    push_bytes(8'h60, 6, 40);
    chk("pre_rst_level", level, 5'd5);
    chk("pre_rst_rd_valid", rd_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_wr_ptr", dut.u_wr_ptr.o_ptr, 4'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    push_bytes(8'h77, 1, 10);
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rd_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("post_rst_rd_valid", got, 1'b1);
    chk("post_rst_head", rd_data, 8'h77);
    drain(20);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_ram_fifo_ctrl

`default_nettype wire
